mpsk_symbol_modulator: RTL and testbench
========================================

MPSK_SYMBOL_MODULATOR -- requirements
Module: mpsk_symbol_modulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the FIFO word width in bits.
REQ-002 The block SHALL have parameter BPS, default 2, the bits per symbol; legal values are 1, 2 and 4, and BPS SHALL divide DATA_W.
REQ-003 The block SHALL have parameter CNT_W, default 16, the width of the clocks-per-symbol counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port enable, input, 1 bit: clock enable; when low, all state freezes.
REQ-007 The block SHALL have port clks_per_sym, input, CNT_W bits: symbol duration in clk cycles; it is sampled at each word load.
REQ-008 The block SHALL have port msb_first, input, 1 bit: symbol order within a word; it is sampled at each word load.
REQ-009 The block SHALL have port diff_en, input, 1 bit: selects differential phase encoding; it is sampled at each word load.
REQ-010 The block SHALL have port sample, input, DATA_W bits: the first-word-fall-through FIFO head data, valid when empty=0.
REQ-011 The block SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-012 The block SHALL have port read, output, 1 bit: FIFO pop strobe, one cycle long.
REQ-013 The block SHALL have port phase, output, BPS bits: the current phase index sent to the carrier/PWM stage.
REQ-014 The block SHALL have port sym_strobe, output, 1 bit: a one-cycle pulse in the first cycle that a new phase value is visible.
REQ-015 The block SHALL have port underrun, output, 1 bit: a one-cycle pulse when the FIFO is empty at a word boundary while in RUN.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in the RUN state.

Function
REQ-017 Two states SHALL exist: IDLE and RUN; NSYM = DATA_W/BPS symbols are sent per word.
REQ-018 Word load SHALL occur when enable=1 and empty=0, in either of two cases: in IDLE, or in RUN at the end of the last symbol.
REQ-019 On a word load, the block SHALL register the following in the same edge: read=1, the shift register loaded from sample, the clock counter cleared to 0, the symbol counter cleared to 0, the mode inputs latched, and phase and sym_strobe updated from the first symbol.
REQ-020 The first symbol and its phase SHALL be visible in the cycle after the load edge, i.e. one cycle after the read pulse edge.
REQ-021 The symbol slice SHALL be taken as follows: if msb_first=1, the top BPS bits, with the shift register shifted left by BPS per symbol; if msb_first=0, the low BPS bits, with the shift register shifted right by BPS.
REQ-022 Phase mapping SHALL be as follows: if diff_en=0, phase <= sym; if diff_en=1, phase <= (phase + sym) mod 2^BPS.
REQ-023 A symbol SHALL end when clock counter = eff-1, where eff = the latched clks_per_sym, and a latched value of 0 is treated as 1.
REQ-024 At the end of a symbol that is not the last symbol, the block SHALL advance the shift register, increment the symbol counter, clear the clock counter, update phase, and pulse sym_strobe.
REQ-025 At the end of the last symbol with empty=0, the block SHALL perform a word load with no gap cycle, keeping the symbol period constant across words.
REQ-026 At the end of the last symbol with empty=1, the block SHALL go to IDLE, pulse underrun, and hold phase at its last value.
REQ-027 In IDLE, phase SHALL hold its value and sym_strobe SHALL be 0.
REQ-028 With enable=0, the counters, state, shift register and phase SHALL hold; read, sym_strobe and underrun SHALL be 0.
REQ-029 Changes to clks_per_sym, msb_first or diff_en in mid-word SHALL take effect only at the next word load.
REQ-030 The clock counter SHALL be CNT_W bits wide; the symbol counter SHALL be $clog2(NSYM) bits wide, minimum 1 bit.
REQ-031 The block SHALL never assert read while empty=1.

Reset
REQ-032 On rst=1, the block SHALL set the state to IDLE and the following to 0: read, phase, sym_strobe, underrun, busy, both counters, the shift register, and the latched modes.
REQ-033 rst SHALL have priority over enable and over any load.
REQ-034 A reset mid-word SHALL discard the remaining symbols; the block SHALL issue no underrun pulse for them.

Structure
REQ-035 A shared package mpsk_pkg SHALL hold the state encoding (ST_IDLE=0, ST_RUN=1) and the NSYM/counter-width helper functions.
REQ-036 The phase mapping of REQ-022 SHALL be a sub-module, mpsk_diff_encoder: inputs sym, diff_en, load strobe; output registered phase.

Verification
REQ-037 Scenario 1: with DATA_W=8, BPS=2, clks_per_sym=4, msb_first=0, diff_en=0, one word 0xE4 -> phase = 0, 1, 2, 3, each held 4 cycles, 4 sym_strobe pulses, 1 read, then underrun pulse and busy=0.
REQ-038 Scenario 2: the same settings with msb_first=1 and word 0xE4 -> phase = 3, 2, 1, 0.
REQ-039 Scenario 3: diff_en=1, phase 0 before the load, word 0x55 (symbols 1,1,1,1) -> phase = 1, 2, 3, 0.
REQ-040 Scenario 4: three words back-to-back, FIFO never empty -> exactly 3 read pulses, one per word, with sym_strobe spacing exactly 4 cycles across word boundaries and no underrun.
REQ-041 Scenario 5: clks_per_sym=0 -> a new symbol every cycle; clks_per_sym changed to 8 in mid-word -> the current word keeps its original period and the next word uses 8.
REQ-042 Scenario 6: enable low for 5 cycles in mid-symbol -> the symbol is stretched by exactly 5 cycles and no strobes occur; rst in mid-word -> phase=0 and IDLE on the next cycle, with no underrun.

Source files
------------

// File: rtl/mpsk_pkg.sv
// Shared definitions for the M-PSK symbol modulator: state encoding and
// word/symbol sizing helpers.
package mpsk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Symbols carried by one FIFO word.
    function automatic int mpsk_nsym(input int data_w, input int bps);
        return data_w / bps;
    endfunction

    // Symbol counter width; a one-symbol word still needs a 1-bit counter.
    function automatic int mpsk_symcnt_w(input int data_w, input int bps);
        int n;
        n = data_w / bps;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mpsk_diff_encoder.sv
// Phase mapper: absolute (phase = sym) or differential
// (phase accumulates sym modulo 2^BPS), registered on each load strobe.
module mpsk_diff_encoder #(
    parameter int BPS = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [BPS-1:0] sym_i,
    input  logic           diff_en_i,
    output logic [BPS-1:0] phase_o
);

    logic [BPS-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (load_i) begin
            // Natural wrap of the BPS-bit sum gives the mod 2^BPS.
            phase_d = diff_en_i ? (phase_q + sym_i) : sym_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/mpsk_symbol_modulator.sv
// Splits FIFO words into BPS-bit symbols, holds each for clks_per_sym clocks
// and emits a phase index with a strobe per symbol; words chain with no gap.
module mpsk_symbol_modulator
    import mpsk_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BPS    = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  clks_per_sym,
    input  logic              msb_first,
    input  logic              diff_en,
    input  logic [DATA_W-1:0] sample,
    input  logic              empty,
    output logic              read,
    output logic [BPS-1:0]    phase,
    output logic              sym_strobe,
    output logic              underrun,
    output logic              busy
);

    localparam int               NSYM     = mpsk_nsym(DATA_W, BPS);
    localparam int               SCW      = mpsk_symcnt_w(DATA_W, BPS);
    localparam logic [SCW-1:0]   LAST_SYM = SCW'(NSYM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d, sreg_shift;
    logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic [CNT_W-1:0]    cps_q, cps_d, end_cnt;
    logic [SCW-1:0]      sym_cnt_q, sym_cnt_d;
    logic                msb_q, msb_d, diff_q, diff_d;
    logic                read_q, strobe_q, underrun_q;
    logic                load, advance, underrun_d;
    logic                sym_end, last_sym, diff_sel;
    logic [BPS-1:0]      sym_next;

    function automatic logic [BPS-1:0] slice_sym(input logic [DATA_W-1:0] w,
                                                 input logic msb);
        return msb ? w[DATA_W-1 -: BPS] : w[BPS-1:0];
    endfunction

    // A latched period of 0 behaves as 1: the symbol ends at count 0.
    assign end_cnt  = (cps_q == '0) ? '0 : (cps_q - CNT_ONE);
    assign sym_end  = (state_q == ST_RUN) && (clk_cnt_q == end_cnt);
    assign last_sym = (sym_cnt_q == LAST_SYM);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: if (!empty) state_d = ST_RUN;
                ST_RUN:  if (sym_end && last_sym && empty) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output / datapath control
    always_comb begin
        load       = 1'b0;
        advance    = 1'b0;
        underrun_d = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: load = !empty;
                ST_RUN: begin
                    if (sym_end) begin
                        if (!last_sym)   advance    = 1'b1;
                        else if (!empty) load       = 1'b1;
                        else             underrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath next-state; the first symbol of a load comes straight from sample
    // using the freshly sampled modes, later symbols from the shifted register.
    always_comb begin
        sreg_shift = msb_q ? (sreg_q << BPS) : (sreg_q >> BPS);
        sreg_d     = sreg_q;
        clk_cnt_d  = clk_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        cps_d      = cps_q;
        msb_d      = msb_q;
        diff_d     = diff_q;
        sym_next   = slice_sym(sreg_shift, msb_q);
        diff_sel   = diff_q;
        if (load) begin
            sreg_d    = sample;
            clk_cnt_d = '0;
            sym_cnt_d = '0;
            cps_d     = clks_per_sym;
            msb_d     = msb_first;
            diff_d    = diff_en;
            sym_next  = slice_sym(sample, msb_first);
            diff_sel  = diff_en;
        end else if (advance) begin
            sreg_d    = sreg_shift;
            clk_cnt_d = '0;
            sym_cnt_d = sym_cnt_q + 1'b1;
        end else if (enable && state_q == ST_RUN) begin
            clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q     <= '0;
            clk_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            cps_q      <= '0;
            msb_q      <= 1'b0;
            diff_q     <= 1'b0;
            read_q     <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            clk_cnt_q  <= clk_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            cps_q      <= cps_d;
            msb_q      <= msb_d;
            diff_q     <= diff_d;
            read_q     <= load;
            strobe_q   <= load | advance;
            underrun_q <= underrun_d;
        end
    end

    mpsk_diff_encoder #(
        .BPS (BPS)
    ) u_enc (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load | advance),
        .sym_i     (sym_next),
        .diff_en_i (diff_sel),
        .phase_o   (phase)
    );

    assign read       = read_q;
    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_mpsk_symbol_modulator.sv
// Directed bench for mpsk_symbol_modulator with a FWFT FIFO model and a
// per-cycle monitor logging strobes, reads and underruns.
module tb_mpsk_symbol_modulator;

    localparam int DATA_W = 8;
    localparam int BPS    = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [CNT_W-1:0]  clks_per_sym = '0;
    logic              msb_first = 1'b0;
    logic              diff_en = 1'b0;
    logic [DATA_W-1:0] sample = '0;
    logic              empty = 1'b1;
    logic              read;
    logic [BPS-1:0]    phase;
    logic              sym_strobe, underrun, busy;

    always #5 clk = ~clk;

    mpsk_symbol_modulator #(
        .DATA_W (DATA_W),
        .BPS    (BPS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clks_per_sym (clks_per_sym),
        .msb_first    (msb_first),
        .diff_en      (diff_en),
        .sample       (sample),
        .empty        (empty),
        .read         (read),
        .phase        (phase),
        .sym_strobe   (sym_strobe),
        .underrun     (underrun),
        .busy         (busy)
    );

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              msb;
        logic              diff;
        int                cps;
        int                ph[4];
    } vec_t;

    vec_t              vecs[7];
    logic [DATA_W-1:0] fifo[$];
    int                st_cyc[$];
    int                st_ph[$];
    int                cyc = 0, n_read = 0, n_unr = 0, unr_cyc = 0;
    int                n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fifo_drive();
        empty  = (fifo.size() == 0);
        sample = empty ? '0 : fifo[0];
    endtask

    task automatic clear_log();
        st_cyc.delete();
        st_ph.delete();
        n_read = 0;
        n_unr  = 0;
        unr_cyc = 0;
    endtask

    // One clock: pop the FIFO on a read seen this cycle, then log outputs.
    task automatic tick();
        logic rd, was_empty;
        rd = read;
        was_empty = empty;
        @(posedge clk);
        #1;
        cyc++;
        if (rd) begin
            check("read_while_empty", int'(was_empty), 0);
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        fifo_drive();
        if (read) n_read++;
        if (sym_strobe) begin
            st_cyc.push_back(cyc);
            st_ph.push_back(int'(phase));
        end
        if (underrun) begin
            n_unr++;
            unr_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo.delete();
        fifo_drive();
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic run_to_underrun(input int budget);
        for (int t = 0; t < budget && n_unr == 0; t++) tick();
        tick();
        tick();
    endtask

    function automatic vec_t mk(input logic [DATA_W-1:0] w, input logic m,
                                input logic d, input int c, input int p0,
                                input int p1, input int p2, input int p3);
        vec_t v;
        v.word = w; v.msb = m; v.diff = d; v.cps = c;
        v.ph[0] = p0; v.ph[1] = p1; v.ph[2] = p2; v.ph[3] = p3;
        return v;
    endfunction

    task automatic check_gaps(input string tag, input int exp_gap[$]);
        for (int i = 0; i < exp_gap.size(); i++) begin
            if (i + 1 < st_cyc.size())
                check($sformatf("%s_gap%0d", tag, i), st_cyc[i+1] - st_cyc[i], exp_gap[i]);
        end
    endtask

    initial begin
        int exp_ph[$];
        int exp_gap[$];
        int eff;

        vecs[0] = mk(8'hE4, 1'b0, 1'b0, 4, 0, 1, 2, 3);
        vecs[1] = mk(8'hE4, 1'b1, 1'b0, 4, 3, 2, 1, 0);
        vecs[2] = mk(8'h55, 1'b0, 1'b1, 4, 1, 2, 3, 0);
        vecs[3] = mk(8'h1B, 1'b0, 1'b0, 2, 3, 2, 1, 0);
        vecs[4] = mk(8'h1B, 1'b0, 1'b1, 3, 3, 1, 2, 2);
        vecs[5] = mk(8'hD2, 1'b1, 1'b1, 1, 3, 0, 0, 2);
        vecs[6] = mk(8'hD2, 1'b0, 1'b0, 0, 2, 0, 1, 3);

        // Reset must win over a pending load with data available.
        rst = 1'b1;
        enable = 1'b1;
        clks_per_sym = 16'd4;
        fifo.push_back(8'hFF);
        fifo_drive();
        tick();
        tick();
        check("rst_phase", int'(phase), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_read", int'(read), 0);
        check("rst_strobe", int'(sym_strobe), 0);
        check("rst_underrun", int'(underrun), 0);
        rst = 1'b0;
        fifo.delete();
        fifo_drive();

        foreach (vecs[k]) begin
            do_reset();
            clks_per_sym = CNT_W'(vecs[k].cps);
            msb_first = vecs[k].msb;
            diff_en = vecs[k].diff;
            enable = 1'b1;
            fifo.push_back(vecs[k].word);
            fifo_drive();
            run_to_underrun(200);
            eff = (vecs[k].cps == 0) ? 1 : vecs[k].cps;
            check($sformatf("v%0d_nstrobe", k), st_ph.size(), 4);
            for (int i = 0; i < 4; i++) begin
                if (i < st_ph.size())
                    check($sformatf("v%0d_phase%0d", k, i), st_ph[i], vecs[k].ph[i]);
                if (i > 0 && i < st_cyc.size())
                    check($sformatf("v%0d_gap%0d", k, i), st_cyc[i] - st_cyc[i-1], eff);
            end
            check($sformatf("v%0d_reads", k), n_read, 1);
            check($sformatf("v%0d_underruns", k), n_unr, 1);
            if (st_cyc.size() > 0)
                check($sformatf("v%0d_unr_delay", k), unr_cyc - st_cyc[st_cyc.size()-1], eff);
            check($sformatf("v%0d_busy_end", k), int'(busy), 0);
            check($sformatf("v%0d_phase_hold", k), int'(phase), vecs[k].ph[3]);
        end

        // Three words back to back: constant 4-cycle spacing, three reads.
        do_reset();
        clks_per_sym = 16'd4; msb_first = 1'b0; diff_en = 1'b0; enable = 1'b1;
        fifo.push_back(8'hE4); fifo.push_back(8'h1B); fifo.push_back(8'hD2);
        fifo_drive();
        for (int t = 0; t < 300 && st_ph.size() < 12 && n_unr == 0; t++) tick();
        check("b2b_unr_before_end", n_unr, 0);
        run_to_underrun(50);
        exp_ph = '{0, 1, 2, 3, 3, 2, 1, 0, 2, 0, 1, 3};
        check("b2b_nstrobe", st_ph.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < st_ph.size()) check($sformatf("b2b_phase%0d", i), st_ph[i], exp_ph[i]);
        end
        exp_gap = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        check_gaps("b2b", exp_gap);
        check("b2b_reads", n_read, 3);
        check("b2b_underruns", n_unr, 1);

        // Period 0 acts as 1; a mid-word change applies only to the next word.
        do_reset();
        clks_per_sym = 16'd0; msb_first = 1'b0; diff_en = 1'b0; enable = 1'b1;
        fifo.push_back(8'hE4); fifo.push_back(8'h1B);
        fifo_drive();
        for (int t = 0; t < 20 && st_ph.size() < 1; t++) tick();
        clks_per_sym = 16'd8;
        run_to_underrun(200);
        check("cps_nstrobe", st_ph.size(), 8);
        exp_gap = '{1, 1, 1, 1, 8, 8, 8};
        check_gaps("cps", exp_gap);
        exp_ph = '{0, 1, 2, 3, 3, 2, 1, 0};
        for (int i = 0; i < 8; i++) begin
            if (i < st_ph.size()) check($sformatf("cps_phase%0d", i), st_ph[i], exp_ph[i]);
        end
        if (st_cyc.size() > 0)
            check("cps_unr_delay", unr_cyc - st_cyc[st_cyc.size()-1], 8);

        // Enable low for 5 cycles mid-symbol stretches that symbol by 5.
        do_reset();
        clks_per_sym = 16'd4; msb_first = 1'b0; diff_en = 1'b0; enable = 1'b1;
        fifo.push_back(8'hE4);
        fifo_drive();
        for (int t = 0; t < 20 && st_ph.size() < 1; t++) tick();
        tick();
        enable = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        check("en_frozen_nstrobe", st_ph.size(), 1);
        check("en_frozen_phase", int'(phase), 0);
        enable = 1'b1;
        run_to_underrun(100);
        check("en_nstrobe", st_ph.size(), 4);
        exp_gap = '{9, 4, 4};
        check_gaps("en", exp_gap);
        check("en_reads", n_read, 1);

        // Reset mid-word drops remaining symbols without an underrun.
        do_reset();
        clks_per_sym = 16'd4; msb_first = 1'b0; diff_en = 1'b0; enable = 1'b1;
        fifo.push_back(8'hE4);
        fifo_drive();
        for (int t = 0; t < 40 && st_ph.size() < 2; t++) tick();
        check("rmw_phase_before", int'(phase), 1);
        rst = 1'b1;
        tick();
        check("rmw_phase", int'(phase), 0);
        check("rmw_busy", int'(busy), 0);
        rst = 1'b0;
        for (int t = 0; t < 20; t++) tick();
        check("rmw_underruns", n_unr, 0);
        check("rmw_nstrobe", st_ph.size(), 2);
        check("rmw_busy_after", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
